// File: rtl/twos_conv_pkg.sv
// ============================================================================
// Module      : twos_conv_pkg
// Description : Shared types and constants for the serial two's-complement to
//               sign-magnitude converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package twos_conv_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_negate_bit.sv
// ============================================================================
// Module      : serial_negate_bit
// Description : One step of the LSB-first serial negation rule: bits pass
//               through until the first 1 has been seen, then are inverted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_negate_bit (
  input  logic data_bit,
  input  logic sign,
  input  logic seen_one,
  output logic out_bit,
  output logic seen_one_next
);

  // Positive operands pass unchanged; negative ones invert after the first 1.
  assign out_bit       = data_bit ^ (sign & seen_one);
  assign seen_one_next = seen_one | data_bit;

endmodule

`default_nettype wire

// File: rtl/twos_to_signmag_serial.sv
// ============================================================================
// Module      : twos_to_signmag_serial
// Description : Bit-serial two's-complement to sign-magnitude converter with
//               valid/ready handshakes; optional out_ovf via TWOS_OVF_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module twos_to_signmag_serial
  import twos_conv_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_sign,
  output logic [W-1:0] out_mag,
  output logic         out_valid,
`ifdef TWOS_OVF_FLAG_EN
  output logic         out_ovf,
`endif
  input  logic         out_ready
);

  localparam int c_cnt_w = $clog2(W);
  localparam logic [W-1:0] c_most_neg = {1'b1, {(W-1){1'b0}}};

  state_t               r_state;
  state_t               w_state_next;
  logic [W-1:0]         r_shreg;
  logic                 r_sign;
  logic                 r_seen_one;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_out_bit;
  logic                 w_seen_one_next;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (int'(r_cnt) == W - 1);

  serial_negate_bit u_negate_bit (
    .data_bit      (r_shreg[0]),
    .sign          (r_sign),
    .seen_one      (r_seen_one),
    .out_bit       (w_out_bit),
    .seen_one_next (w_seen_one_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_next = SHIFT;
      SHIFT:   if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    out_sign  = (r_state == DONE) & r_sign;
    out_mag   = (r_state == DONE) ? r_shreg : '0;
`ifdef TWOS_OVF_FLAG_EN
    // Only the most negative operand maps to sign=1 with magnitude 100..0.
    out_ovf   = (r_state == DONE) & r_sign & (r_shreg == c_most_neg);
`endif
  end

  // Result bits enter at the MSB so after W shifts bit 0 holds the first output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg    <= '0;
      r_sign     <= 1'b0;
      r_seen_one <= 1'b0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_shreg    <= in_data;
      r_sign     <= in_data[W-1];
      r_seen_one <= 1'b0;
      r_cnt      <= '0;
    end else if (r_state == SHIFT) begin
      r_shreg    <= {w_out_bit, r_shreg[W-1:1]};
      r_seen_one <= w_seen_one_next;
      r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_twos_to_signmag_serial.sv
// ============================================================================
// Module      : tb_twos_to_signmag_serial
// Description : Scoreboard bench for twos_to_signmag_serial with directed and
//               randomized operands and a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_twos_to_signmag_serial;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         out_valid;
  logic         out_ready;
`ifdef TWOS_OVF_FLAG_EN
  logic         out_ovf;
`endif

  typedef struct {
    logic         sign;
    logic [W-1:0] mag;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   chk_ready_next = 1'b0;
  bit   prev_valid     = 1'b0;

  twos_to_signmag_serial #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_valid (out_valid),
`ifdef TWOS_OVF_FLAG_EN
    .out_ovf   (out_ovf),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: interpret as a signed integer and take its absolute value.
  function automatic exp_t model(input logic [W-1:0] d, input int acc);
    exp_t e;
    int   v;
    v     = d[W-1] ? int'(d) - (1 << W) : int'(d);
    e.sign = (v < 0);
    e.mag  = W'((v < 0) ? -v : v);
    e.ovf  = (v == -(1 << (W - 1)));
    e.acc  = acc;
    return e;
  endfunction

  // Monitor: compares every valid cycle against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid     = 1'b0;
        chk_ready_next = 1'b0;
      end else begin
        if (chk_ready_next) begin
          check("in_ready_after_pop", in_ready, 1);
          chk_ready_next = 1'b0;
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_out_valid actual=1 required=0 (t=%0t)", $time);
          end else begin
            if (!prev_valid) check("latency", cyc - sb[0].acc, W + 1);
            check("out_sign", out_sign, sb[0].sign);
            check("out_mag", out_mag, sb[0].mag);
`ifdef TWOS_OVF_FLAG_EN
            check("out_ovf", out_ovf, sb[0].ovf);
`endif
            check("in_ready_busy", in_ready, 0);
            if (out_ready) begin
              void'(sb.pop_front());
              chk_ready_next = 1'b1;
            end
          end
        end
        prev_valid = out_valid && !out_ready;
      end
    end
  end

  task automatic send(input logic [W-1:0] d);
    int n;
    n        = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=0 required=1");
    end else begin
      sb.push_back(model(d, cyc));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sign", out_sign, 0);
    check("rst_out_mag", out_mag, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    send(4'b0011);
    send(4'b1011);
    send(4'b1100);
    send(4'b1000);
    send(4'b0111);
    drain();

    // Back-to-back with the consumer always ready
    send(4'b0000);
    send(4'b1111);
    drain();

    // Backpressure, with a competing operand offered while blocked
    out_ready = 1'b0;
    send(4'b0101);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    check("bp_reached_done", out_valid, 1);
    in_data  = 4'b1110;
    in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset in the second SHIFT cycle of 1001
    in_data  = 4'b1001;
    in_valid = 1'b1;
    @(negedge clk);
    check("abort_accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_mag", out_mag, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(4'b0111);
    drain();

    // Random operands with random consumer stalls
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1 send(W'($urandom_range(0, (1 << W) - 1)));
        end
        drain();
      end
      begin
        while (total < 100000 && (sb.size() != 0 || in_valid || cyc < 2)) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_any
    disable fork;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", sb.size());
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
